// File: rtl/dram_xfer_sched_if.sv
// Bundle of requester and datapath signals around the DRAM burst scheduler.
// slave is the scheduler's view; master is the environment (requesters plus datapath).
interface dram_xfer_sched_if;
  // Write requester
  logic        wr_req;
  logic [2:0]  wr_col;
  logic [31:0] wr_data;
  logic        wr_gnt;
  logic        wr_data_rdy;
  logic        wr_done;

  // Read requester
  logic        rd_req;
  logic [2:0]  rd_col;
  logic        rd_gnt;
  logic        rd_valid;
  logic [31:0] rd_data;

  // Data-transfer datapath
  logic        dt_wr_en;
  logic        dt_rd_en;
  logic        dt_clear;
  logic [2:0]  dt_col_choice;
  logic [31:0] dt_memstore;
  logic [31:0] dt_memload;

  logic        busy;

  modport slave (
    input  wr_req, wr_col, wr_data, rd_req, rd_col, dt_memload,
    output wr_gnt, wr_data_rdy, wr_done, rd_gnt, rd_valid, rd_data,
    output dt_wr_en, dt_rd_en, dt_clear, dt_col_choice, dt_memstore, busy
  );

  modport master (
    output wr_req, wr_col, wr_data, rd_req, rd_col, dt_memload,
    input  wr_gnt, wr_data_rdy, wr_done, rd_gnt, rd_valid, rd_data,
    input  dt_wr_en, dt_rd_en, dt_clear, dt_col_choice, dt_memstore, busy
  );
endinterface

// File: rtl/dram_xfer_sched.sv
// Single-channel DRAM burst scheduler: arbitrates one write and one read requester
// and sequences the DQ/DQS datapath through preamble, data beats and bus turnaround.
module dram_xfer_sched #(
  parameter int BURST      = 8,
  parameter int PREAMBLE   = 2,
  parameter int TURNAROUND = 2,
  parameter int CNT_W      = $clog2(PREAMBLE + BURST + TURNAROUND + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  dram_xfer_sched_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_DATA0    = CNT_W'(PREAMBLE);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(PREAMBLE + BURST);
  localparam logic [CNT_W-1:0] CNT_TURN_END = CNT_W'(TURNAROUND - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, TURN} state_t;
  typedef enum logic       {PRIO_READ, PRIO_WRITE}   prio_t;

  state_t           state;
  prio_t            prio;
  logic [CNT_W-1:0] cnt;
  logic             pick_rd;
  logic             pick_wr;
  logic             beat;

  // NOTE: every output of this block is assigned on every path, so no latch is inferred.
  always_comb begin
    pick_rd = bus.rd_req && (!bus.wr_req || prio == PRIO_READ);
    pick_wr = bus.wr_req && !pick_rd;
  end

  assign beat            = (state == WRITE) && (cnt >= CNT_DATA0) && (cnt < CNT_LAST);
  assign bus.wr_data_rdy = beat;
  assign bus.busy        = (state != IDLE);

  // NOTE: non-blocking assignments throughout, so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state             <= IDLE;
      prio              <= PRIO_READ;
      cnt               <= '0;
      bus.wr_gnt        <= 1'b0;
      bus.wr_done       <= 1'b0;
      bus.rd_gnt        <= 1'b0;
      bus.rd_valid      <= 1'b0;
      bus.rd_data       <= '0;
      bus.dt_wr_en      <= 1'b0;
      bus.dt_rd_en      <= 1'b0;
      bus.dt_clear      <= 1'b0;
      bus.dt_col_choice <= '0;
      bus.dt_memstore   <= '0;
    end else begin
      // Pulse outputs default low; the state arms below raise them for one cycle.
      bus.wr_gnt   <= 1'b0;
      bus.wr_done  <= 1'b0;
      bus.rd_gnt   <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.dt_clear <= 1'b0;

      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (pick_rd) begin
            state             <= READ;
            prio              <= PRIO_WRITE;
            bus.rd_gnt        <= 1'b1;
            bus.dt_rd_en      <= 1'b1;
            bus.dt_col_choice <= bus.rd_col;
          end else if (pick_wr) begin
            state             <= WRITE;
            prio              <= PRIO_READ;
            bus.wr_gnt        <= 1'b1;
            bus.dt_wr_en      <= 1'b1;
            bus.dt_col_choice <= bus.wr_col;
          end
        end

        WRITE: begin
          if (beat) begin
            bus.dt_memstore <= bus.wr_data;
          end
          if (cnt == CNT_LAST) begin
            state        <= TURN;
            cnt          <= '0;
            bus.dt_wr_en <= 1'b0;
            bus.wr_done  <= 1'b1;
            bus.dt_clear <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        READ: begin
          // The word selected by dt_col_choice is on memload in the last enabled cycle.
          if (cnt == CNT_LAST) begin
            state        <= TURN;
            cnt          <= '0;
            bus.rd_data  <= bus.dt_memload;
            bus.rd_valid <= 1'b1;
            bus.dt_rd_en <= 1'b0;
            bus.dt_clear <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        TURN: begin
          if (cnt == CNT_TURN_END) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  a_enables_exclusive: assert property (@(posedge CLK) disable iff (RST)
    !(bus.dt_wr_en && bus.dt_rd_en));

  a_cnt_in_range: assert property (@(posedge CLK) disable iff (RST)
    cnt <= CNT_LAST);

endmodule

// File: tb/tb_dram_xfer_sched.sv
// Scoreboard bench for dram_xfer_sched: grants, write beats and read words are queued
// when stimulus is driven and retired when the scheduler produces them.
module tb_dram_xfer_sched;
  localparam int BURST      = 8;
  localparam int PREAMBLE   = 2;
  localparam int TURNAROUND = 2;

  typedef struct packed {
    logic       is_rd;
    logic [2:0] col;
  } gnt_t;

  logic CLK = 1'b0;
  logic RST;

  dram_xfer_sched_if bus ();

  dram_xfer_sched #(
    .BURST      (BURST),
    .PREAMBLE   (PREAMBLE),
    .TURNAROUND (TURNAROUND)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  gnt_t        exp_gnt[$];
  logic [31:0] exp_beat[$];
  logic [31:0] exp_rd[$];
  int          gnt_times[$];

  int rdy_first, rdy_last, n_rdy, n_wr_en, n_rd_en, n_clear;
  int n_wr_done, n_rd_valid, done_at, valid_at, last_busy;

  logic        prev_rdy;
  logic [2:0]  cur_col;
  logic [31:0] next_beat;
  logic [31:0] rd_word;
  int          rd_phase;

  function automatic void clear_stats();
    gnt_times.delete();
    rdy_first  = -1;
    rdy_last   = -1;
    n_rdy      = 0;
    n_wr_en    = 0;
    n_rd_en    = 0;
    n_clear    = 0;
    n_wr_done  = 0;
    n_rd_valid = 0;
    done_at    = -1;
    valid_at   = -1;
    last_busy  = -1;
  endfunction

  // One clock: sample the DUT on the falling edge, retire scoreboard entries,
  // then drive the write-beat source and the datapath read-word model.
  task automatic tick();
    gnt_t        g;
    logic [31:0] e;
    @(negedge CLK);
    cyc++;
    if (RST) begin
      exp_gnt.delete();
      exp_beat.delete();
      exp_rd.delete();
      prev_rdy = 1'b0;
      rd_phase = -1;
    end else begin
      if (prev_rdy) begin
        n_checks++;
        if (exp_beat.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: dt_memstore=%h with no beat pending", bus.dt_memstore);
        end else begin
          e = exp_beat.pop_front();
          if (bus.dt_memstore !== e) begin
            n_fail++;
            $display("FAIL beat: dt_memstore=%h expected %h", bus.dt_memstore, e);
          end
        end
      end
      if (bus.wr_gnt || bus.rd_gnt) begin
        n_checks++;
        if (bus.wr_gnt && bus.rd_gnt) begin
          n_fail++;
          $display("FAIL gnt_overlap: wr_gnt=1 rd_gnt=1 expected one grant");
        end else if (exp_gnt.size() == 0) begin
          n_fail++;
          $display("FAIL gnt_unexpected: wr_gnt=%b rd_gnt=%b with no grant pending",
                   bus.wr_gnt, bus.rd_gnt);
        end else begin
          g = exp_gnt.pop_front();
          if (bus.rd_gnt !== g.is_rd || bus.dt_col_choice !== g.col) begin
            n_fail++;
            $display("FAIL gnt: rd_gnt=%b col=%0d expected rd_gnt=%b col=%0d",
                     bus.rd_gnt, bus.dt_col_choice, g.is_rd, g.col);
          end
          cur_col = g.col;
        end
        gnt_times.push_back(cyc);
      end
      if (bus.busy) begin
        n_checks++;
        if (bus.dt_col_choice !== cur_col) begin
          n_fail++;
          $display("FAIL col_stable: dt_col_choice=%0d expected %0d", bus.dt_col_choice, cur_col);
        end
        last_busy = cyc;
      end
      if (bus.rd_valid) begin
        n_checks++;
        if (exp_rd.size() == 0) begin
          n_fail++;
          $display("FAIL rd_unexpected: rd_data=%h with no read pending", bus.rd_data);
        end else begin
          e = exp_rd.pop_front();
          if (bus.rd_data !== e) begin
            n_fail++;
            $display("FAIL rd_data: rd_data=%h expected %h", bus.rd_data, e);
          end
        end
        n_rd_valid++;
        valid_at = cyc;
      end
      if (bus.dt_wr_en || bus.dt_rd_en) begin
        n_checks++;
        if (bus.dt_wr_en && bus.dt_rd_en) begin
          n_fail++;
          $display("FAIL en_overlap: dt_wr_en=1 dt_rd_en=1 expected at most one");
        end
      end
      if (bus.wr_data_rdy) begin
        if (rdy_first < 0) rdy_first = cyc;
        rdy_last = cyc;
        n_rdy++;
      end
      if (bus.wr_done) begin
        n_wr_done++;
        done_at = cyc;
      end
      n_wr_en  += int'(bus.dt_wr_en);
      n_rd_en  += int'(bus.dt_rd_en);
      n_clear  += int'(bus.dt_clear);
      prev_rdy  = bus.wr_data_rdy;
    end

    if (!RST && bus.wr_data_rdy) begin
      bus.wr_data = next_beat;
      exp_beat.push_back(next_beat);
      next_beat = next_beat + 32'd1;
    end else begin
      bus.wr_data = $urandom;
    end

    if (!RST && bus.rd_gnt) rd_phase = 0;
    else if (rd_phase >= 0 && rd_phase < 100) rd_phase++;
    bus.dt_memload = (rd_phase == PREAMBLE + BURST) ? rd_word : $urandom;
  endtask

  task automatic run(input int n, input bit drop_on_gnt);
    for (int i = 0; i < n; i++) begin
      tick();
      if (drop_on_gnt && bus.wr_gnt) bus.wr_req = 1'b0;
      if (drop_on_gnt && bus.rd_gnt) bus.rd_req = 1'b0;
    end
  endtask

  task automatic apply_reset();
    RST        = 1'b1;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.wr_col = '0;
    bus.rd_col = '0;
    repeat (2) tick();
    RST     = 1'b0;
    cur_col = '0;
    clear_stats();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({bus.wr_gnt, bus.wr_data_rdy, bus.wr_done, bus.rd_gnt, bus.rd_valid,
         bus.dt_wr_en, bus.dt_rd_en, bus.dt_clear, bus.busy} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: wgnt,rdy,wdone,rgnt,rvalid,wen,ren,clr,busy=%b expected 0",
               {bus.wr_gnt, bus.wr_data_rdy, bus.wr_done, bus.rd_gnt, bus.rd_valid,
                bus.dt_wr_en, bus.dt_rd_en, bus.dt_clear, bus.busy});
    end
    n_checks++;
    if (bus.rd_data !== 32'h0 || bus.dt_memstore !== 32'h0 || bus.dt_col_choice !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_data: rd_data=%h memstore=%h col=%0d expected all 0",
               bus.rd_data, bus.dt_memstore, bus.dt_col_choice);
    end
  endtask

  task automatic test_single_write();
    int t0;
    apply_reset();
    t0         = cyc;
    next_beat  = 32'hA0;
    exp_gnt.push_back('{is_rd: 1'b0, col: 3'd5});
    bus.wr_col = 3'd5;
    bus.wr_req = 1'b1;
    run(20, 1'b1);
    n_checks++;
    if (gnt_times.size() != 1 || gnt_times[0] - t0 != 1) begin
      n_fail++;
      $display("FAIL wr_gnt_time: %0d grants, first at %0d expected 1 grant at 1",
               gnt_times.size(), (gnt_times.size() > 0) ? gnt_times[0] - t0 : -1);
    end
    n_checks++;
    if (n_wr_en != PREAMBLE + BURST + 1) begin
      n_fail++;
      $display("FAIL wr_en_len: dt_wr_en high %0d cycles expected %0d", n_wr_en, PREAMBLE + BURST + 1);
    end
    n_checks++;
    if (n_rdy != BURST || rdy_first - t0 != 3 || rdy_last - t0 != 10) begin
      n_fail++;
      $display("FAIL rdy_window: %0d beats at %0d..%0d expected 8 beats at 3..10",
               n_rdy, rdy_first - t0, rdy_last - t0);
    end
    n_checks++;
    if (n_wr_done != 1 || done_at - t0 != 12 || n_clear != 1) begin
      n_fail++;
      $display("FAIL wr_done: %0d pulses at %0d, %0d clears expected 1 pulse at 12, 1 clear",
               n_wr_done, done_at - t0, n_clear);
    end
    n_checks++;
    if (last_busy - t0 != 13) begin
      n_fail++;
      $display("FAIL wr_busy_end: last busy cycle %0d expected 13", last_busy - t0);
    end
    n_checks++;
    if (bus.dt_memstore !== 32'hA7 || exp_beat.size() != 0) begin
      n_fail++;
      $display("FAIL memstore_hold: dt_memstore=%h pending=%0d expected a7 with 0 pending",
               bus.dt_memstore, exp_beat.size());
    end
  endtask

  task automatic test_single_read();
    int t0;
    apply_reset();
    t0      = cyc;
    rd_word = 32'hDEAD_BEEF;
    exp_gnt.push_back('{is_rd: 1'b1, col: 3'd3});
    exp_rd.push_back(32'hDEAD_BEEF);
    bus.rd_col = 3'd3;
    bus.rd_req = 1'b1;
    run(20, 1'b1);
    n_checks++;
    if (n_rd_en != PREAMBLE + BURST + 1 || n_wr_en != 0) begin
      n_fail++;
      $display("FAIL rd_en_len: dt_rd_en %0d cycles, dt_wr_en %0d expected 11 and 0", n_rd_en, n_wr_en);
    end
    n_checks++;
    if (n_rd_valid != 1 || valid_at - t0 != PREAMBLE + BURST + 2) begin
      n_fail++;
      $display("FAIL rd_latency: %0d pulses, at %0d expected 1 pulse at %0d",
               n_rd_valid, valid_at - t0, PREAMBLE + BURST + 2);
    end
    n_checks++;
    if (bus.rd_data !== 32'hDEAD_BEEF || bus.dt_col_choice !== 3'd3 || n_clear != 1) begin
      n_fail++;
      $display("FAIL rd_hold: rd_data=%h col=%0d clears=%0d expected deadbeef col 3, 1 clear",
               bus.rd_data, bus.dt_col_choice, n_clear);
    end
  endtask

  task automatic test_contention();
    int t0;
    apply_reset();
    t0        = cyc;
    rd_word   = 32'h5A5A_0001;
    next_beat = 32'hB0;
    exp_gnt.push_back('{is_rd: 1'b1, col: 3'd6});
    exp_gnt.push_back('{is_rd: 1'b0, col: 3'd2});
    exp_gnt.push_back('{is_rd: 1'b1, col: 3'd6});
    exp_rd.push_back(32'h5A5A_0001);
    exp_rd.push_back(32'h5A5A_0001);
    bus.wr_col = 3'd2;
    bus.rd_col = 3'd6;
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    for (int i = 0; i < 40 && gnt_times.size() < 3; i++) tick();
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    run(20, 1'b1);
    n_checks++;
    if (gnt_times.size() != 3) begin
      n_fail++;
      $display("FAIL contention_count: %0d grants expected 3", gnt_times.size());
    end else begin
      n_checks++;
      if (gnt_times[0] - t0 != 1 || gnt_times[1] - t0 != 15 || gnt_times[2] - t0 != 29) begin
        n_fail++;
        $display("FAIL contention_period: grants at %0d,%0d,%0d expected 1,15,29",
                 gnt_times[0] - t0, gnt_times[1] - t0, gnt_times[2] - t0);
      end
    end
    n_checks++;
    if (n_rd_valid != 2 || n_wr_done != 1 || n_rdy != BURST || exp_rd.size() != 0) begin
      n_fail++;
      $display("FAIL contention_bursts: rd_valid=%0d wr_done=%0d beats=%0d expected 2,1,8",
               n_rd_valid, n_wr_done, n_rdy);
    end
  endtask

  task automatic test_request_during_busy();
    int t0;
    apply_reset();
    t0        = cyc;
    next_beat = 32'hC0;
    rd_word   = 32'hCAFE_0042;
    exp_gnt.push_back('{is_rd: 1'b0, col: 3'd4});
    bus.wr_col = 3'd4;
    bus.wr_req = 1'b1;
    run(6, 1'b1);
    exp_gnt.push_back('{is_rd: 1'b1, col: 3'd1});
    exp_rd.push_back(32'hCAFE_0042);
    bus.rd_col = 3'd1;
    bus.rd_req = 1'b1;
    run(30, 1'b1);
    n_checks++;
    if (gnt_times.size() != 2 || gnt_times[1] - t0 != 15) begin
      n_fail++;
      $display("FAIL busy_wait: %0d grants, read grant at %0d expected 2 grants, read at 15",
               gnt_times.size(), (gnt_times.size() > 1) ? gnt_times[1] - t0 : -1);
    end
    n_checks++;
    if (n_rd_valid != 1 || bus.rd_data !== 32'hCAFE_0042) begin
      n_fail++;
      $display("FAIL busy_read: rd_valid=%0d rd_data=%h expected 1, cafe0042", n_rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_reset_mid_burst();
    int t0;
    int t1;
    apply_reset();
    t0        = cyc;
    next_beat = 32'hD0;
    exp_gnt.push_back('{is_rd: 1'b0, col: 3'd7});
    bus.wr_col = 3'd7;
    bus.wr_req = 1'b1;
    run(7, 1'b1);
    RST = 1'b1;
    tick();
    n_checks++;
    if ({bus.wr_gnt, bus.wr_data_rdy, bus.wr_done, bus.rd_gnt, bus.rd_valid,
         bus.dt_wr_en, bus.dt_rd_en, bus.dt_clear, bus.busy} !== 9'b0) begin
      n_fail++;
      $display("FAIL abort_ctrl: wgnt,rdy,wdone,rgnt,rvalid,wen,ren,clr,busy=%b expected 0",
               {bus.wr_gnt, bus.wr_data_rdy, bus.wr_done, bus.rd_gnt, bus.rd_valid,
                bus.dt_wr_en, bus.dt_rd_en, bus.dt_clear, bus.busy});
    end
    n_checks++;
    if (bus.rd_data !== 32'h0 || bus.dt_memstore !== 32'h0 || bus.dt_col_choice !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_data: rd_data=%h memstore=%h col=%0d expected all 0",
               bus.rd_data, bus.dt_memstore, bus.dt_col_choice);
    end
    RST = 1'b0;
    run(5, 1'b1);
    n_checks++;
    if (n_wr_done != 0 || last_busy - t0 != 7) begin
      n_fail++;
      $display("FAIL abort_quiet: wr_done=%0d last busy %0d expected 0 and 7", n_wr_done, last_busy - t0);
    end

    clear_stats();
    t1        = cyc;
    next_beat = 32'hE0;
    rd_word   = 32'h0BAD_F00D;
    exp_gnt.push_back('{is_rd: 1'b1, col: 3'd5});
    exp_gnt.push_back('{is_rd: 1'b0, col: 3'd2});
    exp_rd.push_back(32'h0BAD_F00D);
    bus.rd_col = 3'd5;
    bus.wr_col = 3'd2;
    bus.rd_req = 1'b1;
    bus.wr_req = 1'b1;
    run(40, 1'b1);
    n_checks++;
    if (gnt_times.size() != 2 || gnt_times[0] - t1 != 1 || gnt_times[1] - t1 != 15) begin
      n_fail++;
      $display("FAIL restart_gnt: %0d grants expected read at 1, write at 15", gnt_times.size());
    end
    n_checks++;
    if (rdy_first - t1 != 17 || n_rdy != BURST || n_wr_done != 1 || n_rd_valid != 1) begin
      n_fail++;
      $display("FAIL restart_burst: first beat %0d beats %0d done %0d valid %0d expected 17,8,1,1",
               rdy_first - t1, n_rdy, n_wr_done, n_rd_valid);
    end
  endtask

  task automatic test_deassert_request();
    int t0;
    apply_reset();
    t0      = cyc;
    rd_word = 32'h1234_5678;
    exp_gnt.push_back('{is_rd: 1'b1, col: 3'd0});
    exp_rd.push_back(32'h1234_5678);
    bus.rd_col = 3'd0;
    bus.rd_req = 1'b1;
    run(5, 1'b0);
    bus.rd_req = 1'b0;
    run(15, 1'b1);
    n_checks++;
    if (n_rd_valid != 1 || valid_at - t0 != 12 || bus.rd_data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL deassert: rd_valid=%0d at %0d rd_data=%h expected 1 at 12, 12345678",
               n_rd_valid, valid_at - t0, bus.rd_data);
    end
  endtask

  initial begin
    RST            = 1'b1;
    bus.wr_req     = 1'b0;
    bus.rd_req     = 1'b0;
    bus.wr_col     = '0;
    bus.rd_col     = '0;
    bus.wr_data    = '0;
    bus.dt_memload = '0;
    prev_rdy       = 1'b0;
    cur_col        = '0;
    next_beat      = '0;
    rd_word        = '0;
    rd_phase       = -1;
    clear_stats();

    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_request_during_busy();
    test_reset_mid_burst();
    test_deassert_request();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
